// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: drains the ps2_keyboard receive FIFO and folds E0/F0 prefixes into single key events.
// Latency: a byte is popped 1 cycle after kb_ready is seen; its event is valid the cycle after the pop.
// Backpressure: ev_valid&&!ev_ready stalls all pops (FIFO absorbs, may overflow -> ovf_flag).
// Optional typematic repeat filter: define PS2_KEY_CTRL_TYPEMATIC_FILTER_EN.

`timescale 1ns/1ps

module ps2_key_ctrl #(
  parameter int TIMEOUT_CYC = 500000,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       kb_data,
  input  logic             kb_ready,
  input  logic             kb_overflow,
  output logic             kb_next_n,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic [CNT_W-1:0] key_cnt,
  output logic             ovf_flag
);

  // Read sequencer states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_POP  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Prefix parser states
  localparam logic [1:0] P_BASE   = 2'd0;
  localparam logic [1:0] P_EXT    = 2'd1;
  localparam logic [1:0] P_BRK    = 2'd2;
  localparam logic [1:0] P_EXTBRK = 2'd3;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  // Timeout counter only has to reach TIMEOUT_CYC-1
  localparam int              TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [1:0]      state;
  logic [7:0]      byte_r;
  logic [1:0]      prefix;
  logic [1:0]      prefix_nxt;
  logic [TO_W-1:0] to_cnt;

  logic            is_ext;
  logic            is_brk;
  logic            emit;
  logic            emit_ext;
  logic            emit_brk;
  logic            drop;
  logic            emit_ok;
  logic            pop_cyc;

  assign is_ext  = (byte_r == CODE_EXT);
  assign is_brk  = (byte_r == CODE_BRK);
  assign pop_cyc = (state == ST_POP);

  // Next prefix state and event decode for the byte held in byte_r
  always_comb begin
    prefix_nxt = prefix;
    emit       = 1'b0;
    emit_ext   = 1'b0;
    emit_brk   = 1'b0;
    case (prefix)
      P_BASE: begin
        if (is_ext) begin
          prefix_nxt = P_EXT;
        end else if (is_brk) begin
          prefix_nxt = P_BRK;
        end else begin
          emit = 1'b1;
        end
      end
      P_EXT: begin
        if (is_brk) begin
          prefix_nxt = P_EXTBRK;
        end else if (is_ext) begin
          // repeated E0 keeps waiting for the real code
          prefix_nxt = P_EXT;
        end else begin
          emit       = 1'b1;
          emit_ext   = 1'b1;
          prefix_nxt = P_BASE;
        end
      end
      P_BRK: begin
        // a prefix after F0 is malformed: drop it and resync
        prefix_nxt = P_BASE;
        if (!is_ext && !is_brk) begin
          emit     = 1'b1;
          emit_brk = 1'b1;
        end
      end
      default: begin
        prefix_nxt = P_BASE;
        if (!is_ext && !is_brk) begin
          emit     = 1'b1;
          emit_ext = 1'b1;
          emit_brk = 1'b1;
        end
      end
    endcase
  end

`ifdef PS2_KEY_CTRL_TYPEMATIC_FILTER_EN
  logic [7:0] held_code;
  logic       held_ext;
  logic       held_v;
  logic       held_match;

  assign held_match = held_v && (held_code == byte_r) && (held_ext == emit_ext);

  // Typematic repeats of the currently held key are suppressed
  always_comb begin
    drop = 1'b0;
    if (emit && !emit_brk && held_match) begin
      drop = 1'b1;
    end
  end

  // Track the last pressed key until its release arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      held_code <= 8'h00;
      held_ext  <= 1'b0;
      held_v    <= 1'b0;
    end else if (pop_cyc && emit) begin
      if (!emit_brk) begin
        if (!held_match) begin
          held_code <= byte_r;
          held_ext  <= emit_ext;
          held_v    <= 1'b1;
        end
      end else if (held_match) begin
        held_v <= 1'b0;
      end
    end
  end
`else
  assign drop = 1'b0;
`endif

  assign emit_ok = emit && !drop;

  // Read sequencer: IDLE latches the head byte, POP strobes nextdata_n, GAP lets ready settle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      kb_next_n <= 1'b1;
      byte_r    <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (kb_ready && !ev_valid) begin
            byte_r    <= kb_data;
            kb_next_n <= 1'b0;
            state     <= ST_POP;
          end
        end
        ST_POP: begin
          kb_next_n <= 1'b1;
          state     <= ST_GAP;
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          kb_next_n <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Prefix register, inter-byte timeout and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      prefix   <= P_BASE;
      to_cnt   <= '0;
      ovf_flag <= 1'b0;
    end else begin
      if (kb_overflow) begin
        ovf_flag <= 1'b1;
      end
      if (pop_cyc) begin
        prefix <= prefix_nxt;
        to_cnt <= '0;
      end else if (prefix != P_BASE) begin
        if (to_cnt == TO_LAST) begin
          // the rest of the sequence never came: resync and flag the loss
          prefix   <= P_BASE;
          to_cnt   <= '0;
          ovf_flag <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  // Event output register with valid/ready hold, plus release counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_valid <= 1'b0;
      ev_code  <= 8'h00;
      ev_ext   <= 1'b0;
      ev_break <= 1'b0;
      key_cnt  <= '0;
    end else if (pop_cyc && emit_ok) begin
      // pops only start with ev_valid low, so this never overwrites a pending event
      ev_valid <= 1'b1;
      ev_code  <= byte_r;
      ev_ext   <= emit_ext;
      ev_break <= emit_brk;
      if (emit_brk) begin
        key_cnt <= key_cnt + 1'b1;
      end
    end else if (ev_valid && ev_ready) begin
      ev_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Testbench for ps2_key_ctrl: FIFO model feeds bytes, a reference parser predicts events,
// a negedge monitor pops the expected-event queue on every accepted event.
// Inputs change 1ns after posedge; outputs are sampled on negedge.

`timescale 1ns/1ps

module tb_ps2_key_ctrl;

  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] kb_data = 8'h00;
  logic       kb_ready = 1'b0;
  logic       kb_overflow = 1'b0;
  logic       ev_ready = 1'b0;
  logic       kb_next_n;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic [7:0] key_cnt;
  logic       ovf_flag;

  ps2_key_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .kb_data     (kb_data),
    .kb_ready    (kb_ready),
    .kb_overflow (kb_overflow),
    .kb_next_n   (kb_next_n),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_code     (ev_code),
    .ev_ext      (ev_ext),
    .ev_break    (ev_break),
    .key_cnt     (key_cnt),
    .ovf_flag    (ovf_flag)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] push_mem [0:4095];
  int         push_wr = 0;
  int         push_rd = 0;
  logic [7:0] fifo_q [$];
  logic [9:0] sb_q [$];     // {code, ext, brk}
  int         cnt_exp = 0;
  int         ev_seen = 0;
  int         nlow = 0;
  logic       prev_next_n = 1'b1;

  // reference parser state: pending prefixes and held key
  bit         m_ext = 0;
  bit         m_brk = 0;
  bit         m_hv = 0;
  bit         m_hext = 0;
  logic [7:0] m_hcode = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_hv = 0; m_hext = 0; m_hcode = 8'h00;
  endtask

  // Reference: a key event is a non-prefix byte, tagged by any E0/F0 seen since the last event.
  // A prefix arriving after F0 invalidates the whole sequence.
  task automatic model_byte(input logic [7:0] b);
    bit keep;
    if (b == 8'hE0 || b == 8'hF0) begin
      if (m_brk) begin
        m_ext = 0; m_brk = 0;
      end else if (b == 8'hF0) begin
        m_brk = 1;
      end else begin
        m_ext = 1;
      end
    end else begin
      keep = 1;
`ifdef PS2_KEY_CTRL_TYPEMATIC_FILTER_EN
      if (!m_brk) begin
        if (m_hv && m_hcode == b && m_hext == m_ext) keep = 0;
        else begin m_hv = 1; m_hcode = b; m_hext = m_ext; end
      end else if (m_hv && m_hcode == b && m_hext == m_ext) begin
        m_hv = 0;
      end
`endif
      if (keep) sb_q.push_back({b, m_ext, m_brk});
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic push(input logic [7:0] b);
    push_mem[push_wr] = b;
    push_wr++;
    model_byte(b);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rtick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      ev_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  function automatic logic [7:0] pick_code();
    logic [7:0] codes [6];
    codes = '{8'h1C, 8'h32, 8'h75, 8'h24, 8'h1D, 8'h5A};
    return codes[$urandom_range(0, 5)];
  endfunction

  task automatic drain(input string name, input int budget);
    int stable;
    stable = 0;
    ev_ready = 1'b1;
    for (int i = 0; i < budget && stable < 4; i++) begin
      tick(1);
      if (push_rd == push_wr && fifo_q.size() == 0 && sb_q.size() == 0 && !ev_valid) stable++;
      else stable = 0;
    end
    if (stable < 4) begin
      n_vec++;
      n_err++;
      $display("FAIL %s drain: %0d expected events outstanding, required 0", name, sb_q.size());
    end
  endtask

  // FIFO model + output monitor, all on negedge
  task automatic background();
    logic [9:0] exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        fifo_q.delete();
        push_rd = push_wr;
        prev_next_n = 1'b1;
      end else begin
        if (!kb_next_n) begin
          nlow++;
          check("next_n_not_back_to_back", 32'(prev_next_n), 32'd1);
          check("no_pop_while_valid", 32'(ev_valid), 32'd0);
          if (fifo_q.size() > 0) void'(fifo_q.pop_front());
          else begin
            n_vec++; n_err++;
            $display("FAIL pop_empty: got pop with empty FIFO, expected none");
          end
        end
        prev_next_n = kb_next_n;
        if (ev_valid && ev_ready) begin
          ev_seen++;
          if (sb_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_event: got code %0h ext %0d brk %0d, expected no event",
                     ev_code, ev_ext, ev_break);
          end else begin
            exp = sb_q.pop_front();
            check("ev_code", 32'(ev_code), 32'(exp[9:2]));
            check("ev_ext", 32'(ev_ext), 32'(exp[1]));
            check("ev_break", 32'(ev_break), 32'(exp[0]));
            if (exp[0]) cnt_exp++;
            check("key_cnt", 32'(key_cnt), 32'(cnt_exp[7:0]));
          end
        end
        while (push_rd != push_wr) begin
          fifo_q.push_back(push_mem[push_rd]);
          push_rd++;
        end
      end
      kb_ready = (fifo_q.size() != 0);
      kb_data  = kb_ready ? fifo_q[0] : 8'h00;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_kb_next_n"}, 32'(kb_next_n), 32'd1);
    check({tag, "_ev_valid"}, 32'(ev_valid), 32'd0);
    check({tag, "_ev_code"}, 32'(ev_code), 32'd0);
    check({tag, "_ev_ext"}, 32'(ev_ext), 32'd0);
    check({tag, "_ev_break"}, 32'(ev_break), 32'd0);
    check({tag, "_key_cnt"}, 32'(key_cnt), 32'd0);
    check({tag, "_ovf_flag"}, 32'(ovf_flag), 32'd0);
  endtask

  initial begin
    int e0;
    int n0;
    int c0;
    int r;
    bit found;
    fork
      background();
    join_none

    rst = 1'b1;
    tick(3);
    check_reset_vals("reset");
    rst = 1'b0;
    tick(2);

    // press/release of a plain key
    ev_ready = 1'b1;
    e0 = ev_seen; n0 = nlow;
    push(8'h1C); push(8'hF0); push(8'h1C);
    drain("t1", 200);
    check("t1_events", 32'(ev_seen - e0), 32'd2);
    check("t1_pops", 32'(nlow - n0), 32'd3);
    check("t1_key_cnt", 32'(key_cnt), 32'd1);

    // extended key press and release
    e0 = ev_seen;
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    drain("t2", 200);
    check("t2_events", 32'(ev_seen - e0), 32'd2);
    check("t2_key_cnt", 32'(key_cnt), 32'd2);

    // consumer stall: second byte must stay in the FIFO
    ev_ready = 1'b0;
    e0 = ev_seen; n0 = nlow;
    push(8'h1C); push(8'h32);
    tick(20);
    check("t3_valid_held", 32'(ev_valid), 32'd1);
    check("t3_code_held", 32'(ev_code), 32'h1C);
    check("t3_single_pop", 32'(nlow - n0), 32'd1);
    check("t3_fifo_ready", 32'(kb_ready), 32'd1);
    drain("t3", 200);
    check("t3_events", 32'(ev_seen - e0), 32'd2);

    // lone prefix followed by silence
    check("t4_ovf_before", 32'(ovf_flag), 32'd0);
    e0 = ev_seen;
    push(8'hE0);
    tick(TO + 20);
    m_ext = 0; m_brk = 0;
    check("t4_ovf_after", 32'(ovf_flag), 32'd1);
    check("t4_no_event", 32'(ev_seen - e0), 32'd0);
    push(8'h1C);
    drain("t4", 200);
    check("t4_resync_event", 32'(ev_seen - e0), 32'd1);

    // random byte stream with random consumer stalls
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) push(8'hE0);
      else if (r == 1) push(8'hF0);
      else push(pick_code());
      rtick($urandom_range(1, 4));
    end
    push(8'h1C);
    drain("random", 6000);

    // 256 press/release pairs wrap the release counter
    c0 = cnt_exp;
    e0 = ev_seen;
    ev_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] c;
      c = pick_code();
      push(c); push(8'hF0); push(c);
      tick(2);
    end
    drain("wrap", 6000);
    check("wrap_events", 32'(ev_seen - e0), 32'd512);
    check("wrap_key_cnt", 32'(key_cnt), 32'(c0[7:0]));

    // reset in the middle of a pop
    push(8'h1C); push(8'hF0); push(8'h1C);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (!kb_next_n) found = 1;
    end
    if (!found) begin
      n_vec++; n_err++;
      $display("FAIL midpop_wait: got no pop within 50 cycles, expected one");
    end
    #1;
    rst = 1'b1;
    sb_q.delete();
    cnt_exp = 0;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_vals("midpop");
    tick(2);
    rst = 1'b0;
    tick(2);

    // typematic repeats
    e0 = ev_seen;
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    drain("typematic", 300);
`ifdef PS2_KEY_CTRL_TYPEMATIC_FILTER_EN
    check("typematic_events", 32'(ev_seen - e0), 32'd2);
`else
    check("typematic_events", 32'(ev_seen - e0), 32'd4);
`endif
    check("typematic_key_cnt", 32'(key_cnt), 32'd1);

    // FIFO overflow indication is sticky and does not stop draining
    check("ovf_clear", 32'(ovf_flag), 32'd0);
    kb_overflow = 1'b1;
    tick(1);
    kb_overflow = 1'b0;
    tick(3);
    check("ovf_set", 32'(ovf_flag), 32'd1);
    e0 = ev_seen;
    push(8'h32);
    drain("ovf", 200);
    check("ovf_still_drains", 32'(ev_seen - e0), 32'd1);
    check("ovf_sticky", 32'(ovf_flag), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
